// File: rtl/pcf8575_pkg.sv
// rtl/pcf8575_pkg.sv - shared types and constants for the PCF8575 target emulator
package pcf8575_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_e;

  localparam logic [6:0] DEFAULT_ADDR = 7'h20;
  localparam logic       ACK_BIT      = 1'b0;
  localparam logic       NACK_BIT     = 1'b1;

endpackage

// File: rtl/pcf8575_i2c_sync_edge.sv
// rtl/pcf8575_i2c_sync_edge.sv - SCL/SDA synchronizers with edge and START/STOP pulses
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [1] is the synchronized value, [2] its previous sample for edge detection
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_s_o    = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_o     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/pcf8575_target.sv
// rtl/pcf8575_target.sv - I2C target emulating a PCF8575 16-bit I/O expander
module pcf8575_target
  import pcf8575_pkg::*;
#(
  parameter logic [6:0] ADDR     = DEFAULT_ADDR,
  parameter int         SDA_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] port_in,
  output logic [15:0] port_out,
  output logic        int_n,
  output logic        wr_commit
);

  logic sda_s, scl_rise, scl_fall, start_p, stop_p;

  i2c_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_s_o   (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_p),
    .stop_o    (stop_p)
  );

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q, tx_q, staged_q, hold_cnt_q;
  logic        rw_q, byte_idx_q, ack_rise_q;
  logic [15:0] pin_s1_q, pin_s2_q, ref_q, snap_q, port_out_q;
  logic        int_n_q, wr_commit_q, sda_oe_q, pend_q, pend_bit_q;

  logic        in_data, byte_end, addr_hit, ack_end;
  logic [7:0]  rx_byte, next_rd_byte;
  logic        drive_req, drive_bit, int_clr, stage, commit, tx_first, tx_shift, tx_next;

  assign in_data      = state_q inside {ST_ADDR, ST_WR_DATA, ST_RD_DATA};
  assign byte_end     = scl_rise && in_data && (bit_cnt_q == 3'd7);
  assign rx_byte      = {shift_q[6:0], sda_s};
  assign addr_hit     = (rx_byte[7:1] == ADDR);
  assign ack_end      = scl_fall && ack_rise_q;
  // byte_idx_q=1 means byte1 was just sent, so the next byte starts a fresh snapshot
  assign next_rd_byte = byte_idx_q ? pin_s2_q[7:0] : snap_q[15:8];

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_p) begin
      state_d = ST_ADDR;
    end else if (stop_p) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADDR:     if (byte_end) state_d = addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK: if (ack_end) state_d = rw_q ? ST_RD_DATA : ST_WR_DATA;
        ST_WR_DATA:  if (byte_end) state_d = ST_WR_ACK;
        ST_WR_ACK:   if (ack_end) state_d = ST_WR_DATA;
        ST_RD_DATA:  if (byte_end) state_d = ST_RD_ACK;
        ST_RD_ACK: begin
          if (scl_rise && (sda_s == NACK_BIT)) state_d = ST_WAIT_STOP;
          else if (ack_end)                    state_d = ST_RD_DATA;
        end
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    drive_req = 1'b0;
    drive_bit = NACK_BIT;
    int_clr   = 1'b0;
    stage     = 1'b0;
    commit    = 1'b0;
    tx_first  = 1'b0;
    tx_shift  = 1'b0;
    tx_next   = 1'b0;
    if (!start_p && !stop_p) begin
      case (state_q)
        ST_ADDR: int_clr = byte_end && addr_hit;
        ST_ADDR_ACK: begin
          if (scl_fall && !ack_rise_q) begin
            drive_req = 1'b1;
            drive_bit = ACK_BIT;
          end else if (ack_end) begin
            drive_req = 1'b1;
            if (rw_q) begin
              drive_bit = snap_q[7];
              tx_first  = 1'b1;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall && !ack_rise_q) begin
            drive_req = 1'b1;
            drive_bit = ACK_BIT;
          end else if (ack_end) begin
            drive_req = 1'b1;
            stage     = !byte_idx_q;
            commit    = byte_idx_q;
          end
        end
        ST_RD_DATA: begin
          if (scl_fall) begin
            drive_req = 1'b1;
            drive_bit = tx_q[6];
            tx_shift  = 1'b1;
          end
        end
        ST_RD_ACK: begin
          if (scl_fall && !ack_rise_q) begin
            drive_req = 1'b1;
          end else if (ack_end) begin
            drive_req = 1'b1;
            drive_bit = next_rd_byte[7];
            tx_next   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      staged_q    <= '0;
      hold_cnt_q  <= '0;
      rw_q        <= 1'b0;
      byte_idx_q  <= 1'b0;
      ack_rise_q  <= 1'b0;
      pin_s1_q    <= 16'hFFFF;
      pin_s2_q    <= 16'hFFFF;
      ref_q       <= 16'hFFFF;
      snap_q      <= 16'hFFFF;
      port_out_q  <= 16'hFFFF;
      int_n_q     <= 1'b1;
      wr_commit_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_bit_q  <= NACK_BIT;
    end else begin
      pin_s1_q    <= port_in;
      pin_s2_q    <= pin_s1_q;
      wr_commit_q <= commit;

      // the clear samples the current inputs, so a same-cycle change lands in the reference
      if (int_clr) begin
        ref_q   <= pin_s2_q;
        snap_q  <= pin_s2_q;
        int_n_q <= 1'b1;
      end else if (pin_s2_q != ref_q) begin
        int_n_q <= 1'b0;
      end

      if (start_p || stop_p) begin
        bit_cnt_q  <= '0;
        byte_idx_q <= 1'b0;
        ack_rise_q <= 1'b0;
        sda_oe_q   <= 1'b0;
        pend_q     <= 1'b0;
      end else begin
        if (scl_rise && in_data) bit_cnt_q <= bit_cnt_q + 3'd1;
        if (scl_rise && (state_q inside {ST_ADDR, ST_WR_DATA})) shift_q <= rx_byte;
        if (byte_end && (state_q == ST_ADDR)) rw_q <= sda_s;

        if (byte_end) ack_rise_q <= 1'b0;
        else if (scl_rise && (state_q inside {ST_ADDR_ACK, ST_WR_ACK, ST_RD_ACK})) ack_rise_q <= 1'b1;

        if (stage) begin
          staged_q   <= shift_q;
          byte_idx_q <= 1'b1;
        end
        if (commit) begin
          port_out_q <= {shift_q, staged_q};
          byte_idx_q <= 1'b0;
        end
        if (tx_first) begin
          tx_q       <= snap_q[7:0];
          byte_idx_q <= 1'b0;
        end
        if (tx_shift) tx_q <= {tx_q[6:0], 1'b0};
        if (tx_next) begin
          tx_q       <= next_rd_byte;
          byte_idx_q <= ~byte_idx_q;
          if (byte_idx_q) snap_q <= pin_s2_q;
        end

        // SDA only moves SDA_HOLD clocks after the SCL fall that requested it
        if (drive_req) begin
          pend_q     <= 1'b1;
          pend_bit_q <= drive_bit;
          hold_cnt_q <= 8'(SDA_HOLD - 1);
        end else if (pend_q) begin
          if (hold_cnt_q == 8'd0) begin
            sda_oe_q <= ~pend_bit_q;
            pend_q   <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q - 8'd1;
          end
        end
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign port_out  = port_out_q;
  assign int_n     = int_n_q;
  assign wr_commit = wr_commit_q;

endmodule
